bias_act_unit: RTL and testbench

- Downstream consumer of the bias memory's 20 parallel bias words.
- Takes a serial stream of per-neuron MAC accumulations, one per neuron in index order 0..NUM_NEURONS-1.
- Adds the matching bias, applies ReLU, saturates to an unsigned activation, and emits it with its neuron index.
- 2-stage pipeline sequenced by a small FSM; feeds the next layer's input buffer.

---
 rtl/bias_act_unit_if.sv | 41 ++++
 rtl/bias_act_unit.sv | 184 ++++++++++++++++++
 tb/tb_bias_act_unit.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/bias_act_unit_if.sv
// Bias/activation bus: accumulation input stream, bias words, activation output stream.
// sat_flag/sat_cnt exist only when BIAS_ACT_SAT_FLAG_EN is defined.
interface bias_act_unit_if #(
    parameter int NUM_NEURONS = 20,
    parameter int BIAS_W      = 10,
    parameter int ACC_W       = 20,
    parameter int OUT_W       = 10
);
    logic                          start;
    logic [ACC_W-1:0]              acc_in;
    logic                          acc_valid;
    logic                          acc_ready;
    logic [NUM_NEURONS*BIAS_W-1:0] bias_flat;
    logic [OUT_W-1:0]              out_data;
    logic [4:0]                    out_idx;
    logic                          out_valid;
    logic                          busy;
    logic                          done;
`ifdef BIAS_ACT_SAT_FLAG_EN
    logic                          sat_flag;
    logic [4:0]                    sat_cnt;

    modport master (
        output start, acc_in, acc_valid, bias_flat,
        input  acc_ready, out_data, out_idx, out_valid, busy, done, sat_flag, sat_cnt
    );
    modport slave (
        input  start, acc_in, acc_valid, bias_flat,
        output acc_ready, out_data, out_idx, out_valid, busy, done, sat_flag, sat_cnt
    );
`else
    modport master (
        output start, acc_in, acc_valid, bias_flat,
        input  acc_ready, out_data, out_idx, out_valid, busy, done
    );
    modport slave (
        input  start, acc_in, acc_valid, bias_flat,
        output acc_ready, out_data, out_idx, out_valid, busy, done
    );
`endif
endinterface

// File: rtl/bias_act_unit.sv
// Adds per-neuron bias to a serial accumulation stream, applies ReLU and unsigned saturation.
// Latency 2 edges from accept to out_valid; acc_ready only in RUN; output has no backpressure.
// BIAS_ACT_SAT_FLAG_EN adds a per-output clip flag and a per-pass clip counter.
module bias_act_unit #(
    parameter int NUM_NEURONS = 20,
    parameter int BIAS_W      = 10,
    parameter int ACC_W       = 20,
    parameter int OUT_W       = 10,
    parameter int BIAS_SHIFT  = 0
) (
    input  logic            clk,
    input  logic            rst,
    bias_act_unit_if.slave  bus
);
    localparam int              SUM_W    = ACC_W + BIAS_SHIFT + 2;
    localparam logic [4:0]      LAST_IDX = 5'(NUM_NEURONS - 1);
    localparam logic [OUT_W-1:0] OUT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [4:0]               cnt_q, cnt_d;
    logic                     s1_vld_q, s1_vld_d;
    logic signed [SUM_W-1:0]  s1_sum_q, s1_sum_d;
    logic [4:0]               s1_idx_q, s1_idx_d;
    logic [OUT_W-1:0]         out_data_q, out_data_d;
    logic [4:0]               out_idx_q, out_idx_d;
    logic                     out_valid_q, out_valid_d;
    logic                     done_q, done_d;
    logic                     busy_q, busy_d;

    logic                     accept;
    logic [BIAS_W-1:0]        bias_sel;
    logic signed [SUM_W-1:0]  acc_ext;
    logic signed [SUM_W-1:0]  bias_ext;
    logic                     sum_neg;
    logic                     sum_over;
    logic [OUT_W-1:0]         clip_val;

    assign accept = bus.acc_valid && (state_q == RUN);

    always_comb begin
        bias_sel = '0;
        for (int i = 0; i < NUM_NEURONS; i++) begin
            if (cnt_q == 5'(i)) begin
                bias_sel = bus.bias_flat[i*BIAS_W +: BIAS_W];
            end
        end
    end

    assign acc_ext  = SUM_W'(signed'(bus.acc_in));
    assign bias_ext = SUM_W'(signed'(bias_sel)) <<< BIAS_SHIFT;

    // Anything above OUT_W bits on a non-negative sum means it exceeds the unsigned range.
    assign sum_neg  = s1_sum_q[SUM_W-1];
    assign sum_over = !sum_neg && (|s1_sum_q[SUM_W-2:OUT_W]);

    always_comb begin
        clip_val = s1_sum_q[OUT_W-1:0];
        if (sum_neg) begin
            clip_val = '0;
        end else if (sum_over) begin
            clip_val = OUT_MAX;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                if (accept) begin
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == LAST_IDX) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (done_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        s1_vld_d    = accept;
        s1_sum_d    = s1_sum_q;
        s1_idx_d    = s1_idx_q;
        if (accept) begin
            s1_sum_d = acc_ext + bias_ext;
            s1_idx_d = cnt_q;
        end

        out_valid_d = s1_vld_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        if (s1_vld_q) begin
            out_data_d = clip_val;
            out_idx_d  = s1_idx_q;
        end

        // The pass ends as the last neuron reaches the output register; busy drops with done.
        done_d = s1_vld_q && (s1_idx_q == LAST_IDX) && (state_q == DRAIN);
        busy_d = (state_d != IDLE) && !done_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            s1_vld_q    <= 1'b0;
            s1_sum_q    <= '0;
            s1_idx_q    <= '0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            s1_vld_q    <= s1_vld_d;
            s1_sum_q    <= s1_sum_d;
            s1_idx_q    <= s1_idx_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.acc_ready = (state_q == RUN);
    assign bus.out_data  = out_data_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

`ifdef BIAS_ACT_SAT_FLAG_EN
    logic       sat_flag_q, sat_flag_d;
    logic [4:0] sat_cnt_q, sat_cnt_d;

    // ReLU zeroing is not a clip; only top-side saturation counts.
    always_comb begin
        sat_flag_d = s1_vld_q && sum_over;
        sat_cnt_d  = sat_cnt_q;
        if ((state_q == IDLE) && bus.start) begin
            sat_cnt_d = '0;
        end else if (sat_flag_d && (sat_cnt_q != 5'd31)) begin
            sat_cnt_d = sat_cnt_q + 5'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_flag_q <= 1'b0;
            sat_cnt_q  <= '0;
        end else begin
            sat_flag_q <= sat_flag_d;
            sat_cnt_q  <= sat_cnt_d;
        end
    end

    assign bus.sat_flag = sat_flag_q;
    assign bus.sat_cnt  = sat_cnt_q;
`endif

endmodule

// File: tb/tb_bias_act_unit.sv
// Directed bench for bias_act_unit: reset, latency, ReLU/saturation, full passes, start/rst interference.
module tb_bias_act_unit;
    localparam int NN = 20;

    typedef struct {
        logic [9:0] data;
        logic [4:0] idx;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    bias_act_unit_if #(.NUM_NEURONS(NN), .BIAS_W(10), .ACC_W(20), .OUT_W(10)) bus ();

    bias_act_unit #(
        .NUM_NEURONS(NN), .BIAS_W(10), .ACC_W(20), .OUT_W(10), .BIAS_SHIFT(0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   n_pass  = 0;
    int   n_total = 0;
    int   n_fail  = 0;
    int   n_out   = 0;
    int   n_done  = 0;
    int   n_clip  = 0;
    int   nidx    = 0;
    int   bias_mem [NN];
    int   acc_tab  [NN];
    exp_t exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic logic [9:0] act(input int acc, input int b);
        int s;
        s = acc + b;
        if (s < 0) return 10'd0;
        if (s > 1023) return 10'd1023;
        return s[9:0];
    endfunction

    // Advance one clock and score any output that appears.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        if (bus.out_valid === 1'b1) begin
            n_out++;
            if (exp_q.size() == 0) begin
                check("unexpected_out", bus.out_valid, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check("out_data", bus.out_data, e.data);
                check("out_idx", bus.out_idx, e.idx);
            end
        end
        if (bus.done === 1'b1) begin
            n_done++;
            check("done_with_idx", {bus.out_valid, bus.out_idx}, {1'b1, 5'd19});
            check("busy_in_done", bus.busy, 1'b0);
        end
    endtask

    task automatic send(input int acc, input int gap);
        int w;
        w = 0;
        bus.acc_valid = 1'b1;
        bus.acc_in    = 20'(acc);
        while (bus.acc_ready !== 1'b1 && w < 20) begin
            step();
            w++;
        end
        if (bus.acc_ready !== 1'b1) check("ready_timeout", bus.acc_ready, 1'b1);
        exp_q.push_back('{act(acc, bias_mem[nidx]), 5'(nidx)});
        if (acc + bias_mem[nidx] > 1023) n_clip++;
        nidx++;
        step();
        bus.acc_valid = 1'b0;
        repeat (gap) step();
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 10 && n_done == 0; i++) step();
        check("done_seen", n_done, 1);
    endtask

    initial begin
        for (int i = 0; i < NN; i++) begin
            bias_mem[i] = (i % 2 == 1) ? -(i * 7) : i * 11;
            acc_tab[i]  = (i * 97) % 1500 - 300;
        end
        bias_mem[0] = 5;    acc_tab[0] = 100;
        bias_mem[1] = -10;  acc_tab[1] = 3;
        bias_mem[2] = 5;    acc_tab[2] = 2000;
        bias_mem[3] = 511;  acc_tab[3] = 600;
        bias_mem[4] = -512; acc_tab[4] = 100;
        acc_tab[5] = 1058;
        acc_tab[6] = 958;
        acc_tab[7] = 49;
        acc_tab[8] = -524288;
        acc_tab[9] = 524287;

        bus.start     = 1'b0;
        bus.acc_valid = 1'b0;
        bus.acc_in    = '0;
        for (int i = 0; i < NN; i++) bus.bias_flat[i*10 +: 10] = 10'(bias_mem[i]);

        // Reset asserted mid-cycle with no clock edge.
        #3 rst = 1'b1;
        #1;
        check("rst_acc_ready", bus.acc_ready, 1'b0);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_data", bus.out_data, 10'd0);
        check("rst_out_idx", bus.out_idx, 5'd0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        step();
        step();
        rst = 1'b0;
        step();
        check("idle_acc_ready", bus.acc_ready, 1'b0);

        // Pass 1: directed latency and clipping, then the rest with random gaps.
        n_out = 0; n_done = 0; nidx = 0; n_clip = 0;
        pulse_start();
        check("start_acc_ready", bus.acc_ready, 1'b1);
        check("start_busy", bus.busy, 1'b1);

        exp_q.push_back('{10'd105, 5'd0});
        bus.acc_valid = 1'b1;
        bus.acc_in    = 20'd100;
        step();
        bus.acc_valid = 1'b0;
        check("lat_edge1_valid", bus.out_valid, 1'b0);
        step();
        check("lat_edge2_valid", bus.out_valid, 1'b1);
        check("idx0_data", bus.out_data, 10'd105);
        check("idx0_idx", bus.out_idx, 5'd0);
        step();
        check("hold_valid", bus.out_valid, 1'b0);
        check("hold_data", bus.out_data, 10'd105);

        exp_q.push_back('{10'd0, 5'd1});
        exp_q.push_back('{10'd1023, 5'd2});
        bus.acc_valid = 1'b1;
        bus.acc_in    = 20'd3;
        step();
        bus.acc_in    = 20'd2000;
        step();
        bus.acc_valid = 1'b0;
        check("relu_data", bus.out_data, 10'd0);
        check("relu_idx", bus.out_idx, 5'd1);
`ifdef BIAS_ACT_SAT_FLAG_EN
        check("relu_no_sat", bus.sat_flag, 1'b0);
`endif
        step();
        check("sat_valid", bus.out_valid, 1'b1);
        check("sat_data", bus.out_data, 10'd1023);
        check("sat_idx", bus.out_idx, 5'd2);
`ifdef BIAS_ACT_SAT_FLAG_EN
        check("sat_flag", bus.sat_flag, 1'b1);
`endif
        nidx   = 3;
        n_clip = 1;
        for (int i = 3; i < NN; i++) send(acc_tab[i], (i == NN - 1) ? 0 : int'($urandom_range(0, 3)));
        check("ready_after_last", bus.acc_ready, 1'b0);
        check("busy_in_drain", bus.busy, 1'b1);
        wait_done();
        // start in the done cycle must be ignored
        pulse_start();
        check("done_start_ignored", bus.acc_ready, 1'b0);
        check("pass1_outputs", n_out, NN);
        check("pass1_queue_empty", exp_q.size(), 0);
`ifdef BIAS_ACT_SAT_FLAG_EN
        check("pass1_sat_cnt", bus.sat_cnt, n_clip);
`endif

        // Pass 2: start pulses during RUN and DRAIN are ignored.
        n_out = 0; n_done = 0; nidx = 0;
        pulse_start();
        check("pass2_acc_ready", bus.acc_ready, 1'b1);
        for (int i = 0; i < NN; i++) begin
            send(acc_tab[i], (i == 9) ? 1 : 0);
            if (i == 9) pulse_start();
        end
        pulse_start();
        wait_done();
        step();
        check("pass2_outputs", n_out, NN);
        check("pass2_done_count", n_done, 1);
        check("pass2_idle_ready", bus.acc_ready, 1'b0);

        // Pass 3: reset with samples in flight.
        n_out = 0; n_done = 0; nidx = 0;
        pulse_start();
        for (int i = 0; i < 7; i++) send(acc_tab[i], 0);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", bus.out_valid, 1'b0);
        check("midrst_acc_ready", bus.acc_ready, 1'b0);
        check("midrst_busy", bus.busy, 1'b0);
        check("midrst_out_idx", bus.out_idx, 5'd0);
        exp_q.delete();
        n_out = 0; n_done = 0;
        step();
        rst = 1'b0;
        repeat (4) step();
        check("post_rst_no_out", n_out, 0);
        check("post_rst_no_done", n_done, 0);

        nidx = 0;
        pulse_start();
        send(acc_tab[0], 2);
        check("restart_first_out", n_out, 1);
        check("restart_queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
